// File: rtl/jt12_slotram.sv
// Slot RAM for JT12 time-multiplexed operator/channel state.
// After reset it sweeps INIT into every entry, then serves one write and one registered read per clk_en.
module jt12_slotram #(
    parameter int unsigned DW        = 44,
    parameter int unsigned AW        = 5,
    parameter int unsigned INIT_ONES = 7,
    parameter int unsigned BYPASS    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] q,
    output logic          busy
);

    localparam int unsigned   N         = 2 ** AW;
    localparam logic [DW-1:0] INIT_WORD = ~({DW{1'b1}} >> INIT_ONES);
    localparam logic [AW-1:0] LAST_SLOT = AW'(N - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    // Selects which registered source drives q; keeps both muxes outside the array.
    typedef enum logic [1:0] {
        SEL_INIT,
        SEL_RAM,
        SEL_BYP
    } sel_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    sel_t          sel_q, sel_d;
    logic [DW-1:0] byp_q, byp_d;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rd_q;

    // Initial image matches the post-sweep contents.
    logic [DW-1:0] ram_mem [N] = '{default: INIT_WORD};

    // Next-state, sweep address mux and bypass decision.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        sel_d     = sel_q;
        byp_d     = byp_q;
        ram_we    = 1'b0;
        ram_waddr = wr_addr;
        ram_wdata = data;

        if (clk_en && !rst) begin
            case (state_q)
                ST_CLEAR: begin
                    ram_we    = 1'b1;
                    ram_waddr = cnt_q;
                    ram_wdata = INIT_WORD;
                    sel_d     = SEL_INIT;
                    if (cnt_q == LAST_SLOT) begin
                        state_d = ST_RUN;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
                ST_RUN: begin
                    ram_we = wr_en;
                    busy_d = 1'b0;
                    if ((BYPASS != 0) && wr_en && (rd_addr == wr_addr)) begin
                        sel_d = SEL_BYP;
                        byp_d = data;
                    end else begin
                        sel_d = SEL_RAM;
                    end
                end
            endcase
        end
    end

    // Control registers; reset wins over clk_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            sel_q   <= SEL_INIT;
            byp_q   <= INIT_WORD;
        end else if (clk_en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            sel_q   <= sel_d;
            byp_q   <= byp_d;
        end
    end

    // Plain array with registered read so it infers block RAM (read-old-data on collision).
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ram_waddr] <= ram_wdata;
        end
        if (clk_en) begin
            ram_rd_q <= ram_mem[rd_addr];
        end
    end

    always_comb begin
        case (sel_q)
            SEL_RAM: q = ram_rd_q;
            SEL_BYP: q = byp_q;
            default: q = INIT_WORD;
        endcase
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_jt12_slotram.sv
// Scoreboard bench for jt12_slotram: one BYPASS=1 and one BYPASS=0 instance share the stimulus.
module tb_jt12_slotram;

    localparam logic [43:0] INIT = 44'hFE000000000;

    logic        clk;
    logic        rst, clk_en, wr_en;
    logic [4:0]  wr_addr, rd_addr;
    logic [43:0] data;
    logic [43:0] q1, q0;
    logic        busy1, busy0;

    jt12_slotram #(.DW(44), .AW(5), .INIT_ONES(7), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .clk_en(clk_en), .wr_en(wr_en), .wr_addr(wr_addr),
        .rd_addr(rd_addr), .data(data), .q(q1), .busy(busy1)
    );

    jt12_slotram #(.DW(44), .AW(5), .INIT_ONES(7), .BYPASS(0)) u_nobyp (
        .clk(clk), .rst(rst), .clk_en(clk_en), .wr_en(wr_en), .wr_addr(wr_addr),
        .rd_addr(rd_addr), .data(data), .q(q0), .busy(busy0)
    );

    typedef struct {
        int          id;
        logic [43:0] q1;
        logic [43:0] q0;
        logic        busy;
        bit          qchk;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;
    bit   chk_req = 1'b0;
    bit   chk_now = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    // Marks the edges whose outcome the monitor must check.
    always @(posedge clk) chk_now <= chk_req;

    // Monitor: pops one expectation per marked edge and compares both instances.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_now) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_underflow: output with no expectation");
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (busy1 !== e.busy) begin
                        errors++;
                        $display("FAIL busy_byp step %0d: got %b want %b", e.id, busy1, e.busy);
                    end
                    checks++;
                    if (busy0 !== e.busy) begin
                        errors++;
                        $display("FAIL busy_nobyp step %0d: got %b want %b", e.id, busy0, e.busy);
                    end
                    if (e.qchk) begin
                        checks++;
                        if (q1 !== e.q1) begin
                            errors++;
                            $display("FAIL q_byp step %0d: got %h want %h", e.id, q1, e.q1);
                        end
                        checks++;
                        if (q0 !== e.q0) begin
                            errors++;
                            $display("FAIL q_nobyp step %0d: got %h want %h", e.id, q0, e.q0);
                        end
                    end
                end
            end
        end
    end

    // One clock of stimulus plus the expected outcome after the coming edge.
    task automatic cyc(input logic r, input logic en, input logic we,
                       input logic [4:0] wa, input logic [4:0] ra, input logic [43:0] d,
                       input bit qc, input logic [43:0] e1, input logic [43:0] e0,
                       input logic eb);
        exp_t e;
        rst = r; clk_en = en; wr_en = we; wr_addr = wa; rd_addr = ra; data = d;
        chk_req = 1'b1;
        step_id++;
        e.id = step_id; e.q1 = e1; e.q0 = e0; e.busy = eb; e.qchk = qc;
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic sweep_full(input logic we, input logic [4:0] wa, input logic [43:0] d);
        for (int k = 1; k <= 32; k++)
            cyc(1'b0, 1'b1, we, wa, 5'd0, d, 1'b1, INIT, INIT, (k < 32));
    endtask

    task automatic read_all_init();
        for (int i = 0; i < 32; i++)
            cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'(i), 44'd0, 1'b1, INIT, INIT, 1'b0);
    endtask

    initial begin
        rst = 1'b0; clk_en = 1'b0; wr_en = 1'b0; wr_addr = '0; rd_addr = '0; data = '0;
        @(negedge clk);
        #1;

        // Reset and full sweep, then all slots read INIT.
        cyc(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 44'd0, 1'b1, INIT, INIT, 1'b1);
        sweep_full(1'b0, 5'd0, 44'd0);
        read_all_init();

        // Write slot 5, read it back, neighbour untouched.
        cyc(1'b0, 1'b1, 1'b1, 5'd5, 5'd0, 44'h123456789AB, 1'b1, INIT, INIT, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'd5, 44'd0, 1'b1, 44'h123456789AB, 44'h123456789AB, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'd6, 44'd0, 1'b1, INIT, INIT, 1'b0);

        // Same-address collision on slot 9.
        cyc(1'b0, 1'b1, 1'b1, 5'd9, 5'd9, 44'h00000000ABC, 1'b1, 44'h00000000ABC, INIT, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'd9, 44'd0, 1'b1, 44'h00000000ABC, 44'h00000000ABC, 1'b0);

        // clk_en toggling during the sweep, with ignored write pulses on the idle cycles.
        cyc(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 44'd0, 1'b1, INIT, INIT, 1'b1);
        for (int k = 1; k <= 64; k++) begin
            if (k % 2 == 1)
                cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 44'd0, 1'b1, INIT, INIT, ((k + 1) / 2 < 32));
            else
                cyc(1'b0, 1'b0, 1'b1, 5'd2, 5'd2, 44'h55, 1'b1, INIT, INIT, ((k / 2) < 32));
        end
        cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'd5, 44'd0, 1'b1, INIT, INIT, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 5'd2, 5'd2, 44'h77, 1'b1, INIT, INIT, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'd2, 44'd0, 1'b1, INIT, INIT, 1'b0);

        // Reset at cnt=17 with writes to slot 3 attempted throughout the busy window.
        cyc(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 44'd0, 1'b1, INIT, INIT, 1'b1);
        for (int k = 1; k <= 17; k++)
            cyc(1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 44'h1, 1'b1, INIT, INIT, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 5'd3, 5'd3, 44'h1, 1'b1, INIT, INIT, 1'b1);
        sweep_full(1'b1, 5'd3, 44'h1);
        cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'd3, 44'd0, 1'b1, INIT, INIT, 1'b0);

        // Fill every slot with its index (forwarded vs old data), then reset during RUN.
        for (int i = 0; i < 32; i++)
            cyc(1'b0, 1'b1, 1'b1, 5'(i), 5'(i), 44'(i), 1'b1, 44'(i), INIT, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'd7, 44'd0, 1'b1, 44'd7, 44'd7, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 5'd0, 5'd7, 44'd0, 1'b1, INIT, INIT, 1'b1);
        sweep_full(1'b0, 5'd0, 44'd0);
        read_all_init();

        chk_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries remain, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
